// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers per-digit hex values from a multiplexed 7-segment bus
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int SEG_ACT_LOW   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [6:0]            i_seg,
    input  logic [DIGITS-1:0]     i_dig_sel,
    output logic [4*DIGITS-1:0]   o_hex,
    output logic [DIGITS-1:0]     o_blank,
    output logic [DIGITS-1:0]     o_err,
    output logic                  o_upd,
    output logic [2:0]            o_upd_idx
);

    localparam int BW = DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_TRIG = CW'(STABLE_CYCLES - 1);

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_COMMIT = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [BW-1:0]      r_s1;
    logic [BW-1:0]      r_s2;
    logic [BW-1:0]      r_s3;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_state;
    logic [6:0]         r_cap_seg;
    logic [2:0]         r_upd_idx;
    logic [4*DIGITS-1:0] r_hex;
    logic [DIGITS-1:0]  r_blank;
    logic [DIGITS-1:0]  r_err;

    logic               w_change;
    logic [BW-1:0]      w_bus;
    logic [6:0]         w_seg;
    logic [DIGITS-1:0]  w_sel;
    logic               w_onehot;
    logic [2:0]         w_idx;
    logic               w_hit;
    logic [3:0]         w_val;

    // Polarity is normalised after synchronisation; change detection is polarity-agnostic.
    assign w_change = (r_s2 != r_s3);
    assign w_bus    = (SEG_ACT_LOW != 0) ? ~r_s2 : r_s2;
    assign w_seg    = w_bus[6:0];
    assign w_sel    = w_bus[BW-1:7];
    assign w_onehot = $onehot(w_sel);

    // Two-flop synchronizer plus a previous-value stage for change detection.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= {i_dig_sel, i_seg};
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Binary index of the (one-hot) digit select.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_sel[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    // Segment pattern to hex value; a miss is an error unless the pattern is blank.
    always_comb begin
        w_hit = 1'b1;
        w_val = 4'h0;
        case (r_cap_seg)
            7'h7E: w_val = 4'h0;
            7'h30: w_val = 4'h1;
            7'h6D: w_val = 4'h2;
            7'h79: w_val = 4'h3;
            7'h33: w_val = 4'h4;
            7'h5B: w_val = 4'h5;
            7'h5F: w_val = 4'h6;
            7'h70: w_val = 4'h7;
            7'h7F: w_val = 4'h8;
            7'h7B: w_val = 4'h9;
            7'h77: w_val = 4'hA;
            7'h1F: w_val = 4'hB;
            7'h4E: w_val = 4'hC;
            7'h3D: w_val = 4'hD;
            7'h4F: w_val = 4'hE;
            7'h47: w_val = 4'hF;
            default: w_hit = 1'b0;
        endcase
    end

    // Stability counter and WAIT/COMMIT/HOLD sequencing; the pattern is captured on entry to COMMIT
    // so a bus change during the commit cycle cannot leak a partial value into the slot.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_state   <= ST_WAIT;
            r_cap_seg <= '0;
            r_upd_idx <= '0;
        end else begin
            if (w_change) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CW'(1);
            end
            case (r_state)
                ST_WAIT: begin
                    if (!w_change && (r_cnt == CNT_TRIG) && w_onehot) begin
                        r_state   <= ST_COMMIT;
                        r_cap_seg <= w_seg;
                        r_upd_idx <= w_idx;
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_change) begin
                        r_state <= ST_WAIT;
                    end
                end
                default: begin
                    r_state <= ST_WAIT;
                end
            endcase
        end
    end

    // Slot update: only the captured digit is written, at the end of the COMMIT cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hex   <= '0;
            r_blank <= '1;
            r_err   <= '0;
        end else if (r_state == ST_COMMIT) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (r_upd_idx == 3'(i)) begin
                    if (r_cap_seg == 7'h00) begin
                        r_blank[i] <= 1'b1;
                        r_err[i]   <= 1'b0;
                    end else if (w_hit) begin
                        r_hex[4*i +: 4] <= w_val;
                        r_blank[i]      <= 1'b0;
                        r_err[i]        <= 1'b0;
                    end else begin
                        r_blank[i] <= 1'b0;
                        r_err[i]   <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_hex     = r_hex;
    assign o_blank   = r_blank;
    assign o_err     = r_err;
    assign o_upd     = (r_state == ST_COMMIT);
    assign o_upd_idx = r_upd_idx;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    localparam int DIGITS = 4;
    localparam int SC     = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic [15:0] o_hex;
    logic [3:0]  o_blank;
    logic [3:0]  o_err;
    logic        o_upd;
    logic [2:0]  o_upd_idx;

    typedef struct packed {
        logic [2:0] idx;
        logic [6:0] seg;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [15:0] m_hex;
    logic [3:0]  m_blank;
    logic [3:0]  m_err;
    logic [4:0]  mon_d;
    bit          pending;
    int          n_checks;
    int          n_pass;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(SC), .SEG_ACT_LOW(0)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_seg     (seg),
        .i_dig_sel (dig_sel),
        .o_hex     (o_hex),
        .o_blank   (o_blank),
        .o_err     (o_err),
        .o_upd     (o_upd),
        .o_upd_idx (o_upd_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        case (s)
            7'h7E: return 5'h10;
            7'h30: return 5'h11;
            7'h6D: return 5'h12;
            7'h79: return 5'h13;
            7'h33: return 5'h14;
            7'h5B: return 5'h15;
            7'h5F: return 5'h16;
            7'h70: return 5'h17;
            7'h7F: return 5'h18;
            7'h7B: return 5'h19;
            7'h77: return 5'h1A;
            7'h1F: return 5'h1B;
            7'h4E: return 5'h1C;
            7'h3D: return 5'h1D;
            7'h4F: return 5'h1E;
            7'h47: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    // Scoreboard: each upd pops one expected commit; the next negedge checks the slot outputs.
    always @(negedge clk) begin
        if (pending) begin
            pending = 1'b0;
            n_checks++;
            if (o_hex !== m_hex || o_blank !== m_blank || o_err !== m_err)
                $display("FAIL commit_outputs: hex=%h blank=%b err=%b expected hex=%h blank=%b err=%b",
                         o_hex, o_blank, o_err, m_hex, m_blank, m_err);
            else
                n_pass++;
        end
        if (o_upd === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_upd: upd_idx=%0d with no commit expected", o_upd_idx);
            end else begin
                mon_e = sb_q.pop_front();
                if (o_upd_idx !== mon_e.idx)
                    $display("FAIL upd_idx: got %0d expected %0d", o_upd_idx, mon_e.idx);
                else
                    n_pass++;
                mon_d = ref_decode(mon_e.seg);
                if (mon_e.seg == 7'h00) begin
                    m_blank[mon_e.idx] = 1'b1;
                    m_err[mon_e.idx]   = 1'b0;
                end else if (mon_d[4]) begin
                    m_hex[4*mon_e.idx +: 4] = mon_d[3:0];
                    m_blank[mon_e.idx]      = 1'b0;
                    m_err[mon_e.idx]        = 1'b0;
                end else begin
                    m_blank[mon_e.idx] = 1'b0;
                    m_err[mon_e.idx]   = 1'b1;
                end
                pending = 1'b1;
            end
        end
    end

    task automatic model_reset();
        m_hex   = '0;
        m_blank = '1;
        m_err   = '0;
        sb_q.delete();
        pending = 1'b0;
    endtask

    task automatic drive(input logic [3:0] sel, input logic [6:0] s);
        dig_sel = sel;
        seg     = s;
    endtask

    task automatic push(input logic [2:0] idx, input logic [6:0] s);
        exp_t e;
        e.idx = idx;
        e.seg = s;
        sb_q.push_back(e);
    endtask

    task automatic run(input int n, output int ups);
        ups = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (o_upd === 1'b1) ups++;
        end
    endtask

    task automatic test_reset();
        int ups;
        reset = 1'b1;
        drive(4'b0000, 7'h00);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (o_hex !== 16'h0000) $display("FAIL reset_hex: got %h expected 0000", o_hex); else n_pass++;
        n_checks++;
        if (o_blank !== 4'hF) $display("FAIL reset_blank: got %b expected 1111", o_blank); else n_pass++;
        n_checks++;
        if (o_err !== 4'h0) $display("FAIL reset_err: got %b expected 0000", o_err); else n_pass++;
        n_checks++;
        if (o_upd !== 1'b0 || o_upd_idx !== 3'd0)
            $display("FAIL reset_upd: upd=%b idx=%0d expected 0/0", o_upd, o_upd_idx);
        else n_pass++;
        run(40, ups);
        n_checks++;
        if (ups !== 0) $display("FAIL idle_no_upd: got %0d pulses expected 0", ups); else n_pass++;
    endtask

    task automatic test_single_digit();
        int ups;
        int first_j;
        ups = 0;
        first_j = -1;
        @(negedge clk);
        drive(4'b0001, 7'h79);
        push(3'd0, 7'h79);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (o_upd === 1'b1) begin
                ups++;
                if (first_j < 0) first_j = j;
            end
        end
        n_checks++;
        if (ups !== 1) $display("FAIL single_count: got %0d pulses expected 1", ups); else n_pass++;
        n_checks++;
        if (first_j !== SC + 2)
            $display("FAIL single_latency: upd after edge k+%0d expected k+%0d", first_j, SC + 2);
        else n_pass++;
        n_checks++;
        if (o_hex[3:0] !== 4'h3 || o_blank[0] !== 1'b0)
            $display("FAIL single_value: hex0=%h blank0=%b expected 3/0", o_hex[3:0], o_blank[0]);
        else n_pass++;
    endtask

    task automatic test_scan();
        int ups;
        int total;
        logic [6:0] pats [4];
        pats  = '{7'h4F, 7'h6D, 7'h30, 7'h7E};
        total = 0;
        for (int d = 3; d >= 0; d--) begin
            drive(4'(1 << d), pats[d]);
            push(3'(d), pats[d]);
            run(20, ups);
            total += ups;
        end
        n_checks++;
        if (total !== 4) $display("FAIL scan_count: got %0d pulses expected 4", total); else n_pass++;
        n_checks++;
        if (o_hex !== 16'h012E || o_blank !== 4'h0 || o_err !== 4'h0)
            $display("FAIL scan_value: hex=%h blank=%b err=%b expected 012E/0000/0000", o_hex, o_blank, o_err);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int u0, u1, u2, u3, u4;
        drive(4'b0010, 7'h5B);
        run(10, u0);
        drive(4'b0010, 7'h70);
        push(3'd1, 7'h70);
        run(8, u1);
        drive(4'b0010, 7'h7F);
        run(1, u2);
        drive(4'b0010, 7'h70);
        run(10, u3);
        n_checks++;
        if (u0 + u1 + u2 + u3 !== 0)
            $display("FAIL glitch_restart: got %0d early pulses expected 0", u0 + u1 + u2 + u3);
        else n_pass++;
        run(20, u4);
        n_checks++;
        if (u4 !== 1) $display("FAIL glitch_count: got %0d pulses expected 1", u4); else n_pass++;
        n_checks++;
        if (o_hex[7:4] !== 4'h7) $display("FAIL glitch_value: hex1=%h expected 7", o_hex[7:4]); else n_pass++;
    endtask

    task automatic test_err_multi();
        int ups;
        drive(4'b0100, 7'h01);
        push(3'd2, 7'h01);
        run(22, ups);
        n_checks++;
        if (ups !== 1) $display("FAIL err_count: got %0d pulses expected 1", ups); else n_pass++;
        n_checks++;
        if (o_err[2] !== 1'b1 || o_hex[11:8] !== 4'h1 || o_blank[2] !== 1'b0)
            $display("FAIL err_value: err2=%b hex2=%h blank2=%b expected 1/1/0", o_err[2], o_hex[11:8], o_blank[2]);
        else n_pass++;
        drive(4'b0110, 7'h7E);
        run(50, ups);
        n_checks++;
        if (ups !== 0) $display("FAIL multi_sel: got %0d pulses expected 0", ups); else n_pass++;
    endtask

    task automatic test_reset_priority();
        int ups;
        drive(4'b1000, 7'h30);
        push(3'd3, 7'h30);
        run(22, ups);
        n_checks++;
        if (ups !== 1) $display("FAIL hold_commit: got %0d pulses expected 1", ups); else n_pass++;
        reset = 1'b1;
        drive(4'b0000, 7'h00);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (o_hex !== 16'h0 || o_blank !== 4'hF || o_err !== 4'h0 || o_upd !== 1'b0 || o_upd_idx !== 3'd0)
            $display("FAIL hold_reset: hex=%h blank=%b err=%b upd=%b idx=%0d expected reset values",
                     o_hex, o_blank, o_err, o_upd, o_upd_idx);
        else n_pass++;
        run(5, ups);
        drive(4'b0001, 7'h7E);
        run(SC + 2, ups);
        reset = 1'b1;
        drive(4'b0000, 7'h00);
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (ups !== 0 || o_upd !== 1'b0 || o_hex !== 16'h0 || o_blank !== 4'hF || o_err !== 4'h0)
            $display("FAIL precommit_reset: pulses=%0d upd=%b hex=%h blank=%b err=%b expected 0/0/0000/1111/0000",
                     ups, o_upd, o_hex, o_blank, o_err);
        else n_pass++;
        run(40, ups);
        n_checks++;
        if (ups !== 0) $display("FAIL dropped_commit: got %0d pulses expected 0", ups); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        seg      = 7'h00;
        dig_sel  = 4'b0000;
        model_reset();
        test_reset();
        test_single_digit();
        test_scan();
        test_glitch();
        test_err_multi();
        test_reset_priority();
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: %0d commits never seen, expected 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
